// File: rtl/aes_round_ctrl.sv
// rtl/aes_round_ctrl.sv - iterative AES-128 round sequencer
// Drives state-register select/load, waits out MixColumns latency, requests round keys.
module aes_round_ctrl #(
  parameter int NR      = 10,
  parameter int MIX_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       key_ready,
  output logic       busy,
  output logic       done,
  output logic [3:0] round,
  output logic       rk_req,
  output logic [3:0] rk_idx,
  output logic       state_ld,
  output logic [1:0] in_sel
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    MIXW  = 3'd2,
    ARK   = 3'd3,
    FINAL = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [3:0] NR4  = 4'(NR);
  localparam logic [3:0] LAT4 = 4'(MIX_LAT);

  state_t     state;
  logic [3:0] round_q;
  logic [3:0] wcnt;
  logic       done_q;
  logic [1:0] sel_c;
  logic [3:0] round_nx;

  assign round_nx = round_q + 4'd1;

  always_comb begin
    busy   = 1'b0;
    rk_req = 1'b0;
    rk_idx = 4'd0;
    sel_c  = 2'b00;
    case (state)
      INIT: begin
        busy   = 1'b1;
        rk_req = 1'b1;
        sel_c  = 2'b01;
      end
      MIXW: busy = 1'b1;
      ARK: begin
        busy   = 1'b1;
        rk_req = 1'b1;
        rk_idx = round_q;
        sel_c  = 2'b10;
      end
      FINAL: begin
        busy   = 1'b1;
        rk_req = 1'b1;
        rk_idx = NR4;
        sel_c  = 2'b11;
      end
      default: ;
    endcase
  end

  // abort blocks the load in the same cycle it is seen
  assign state_ld = rk_req & key_ready & ~abort;
  assign in_sel   = state_ld ? sel_c : 2'b00;
  assign done     = done_q;
  assign round    = round_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      round_q <= 4'd0;
      wcnt    <= 4'd0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (busy && abort) begin
        state   <= IDLE;
        round_q <= 4'd0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state   <= INIT;
              round_q <= 4'd0;
            end
          end
          INIT: begin
            if (key_ready) begin
              round_q <= 4'd1;
              if (NR == 1) begin
                state <= FINAL;
              end else begin
                state <= MIXW;
                wcnt  <= LAT4;
              end
            end
          end
          MIXW: begin
            if (wcnt == 4'd1) state <= ARK;
            else              wcnt  <= wcnt - 4'd1;
          end
          ARK: begin
            if (key_ready) begin
              round_q <= round_nx;
              if (round_nx == NR4) begin
                state <= FINAL;
              end else begin
                state <= MIXW;
                wcnt  <= LAT4;
              end
            end
          end
          FINAL: begin
            if (key_ready) begin
              state  <= DONE;
              done_q <= 1'b1;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb/tb_aes_round_ctrl.sv - self-checking bench for aes_round_ctrl
// Three instances: defaults, MIX_LAT=3, NR=1, driven by shared stimulus.
module tb_aes_round_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic key_ready = 1'b0;
  logic abort = 1'b0;

  logic       busy_w   [3];
  logic       done_w   [3];
  logic       rk_req_w [3];
  logic       ld_w     [3];
  logic [3:0] round_w  [3];
  logic [3:0] idx_w    [3];
  logic [1:0] sel_w    [3];

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_dut
      aes_round_ctrl #(
        .NR      (g == 2 ? 1 : 10),
        .MIX_LAT (g == 1 ? 3 : 1)
      ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .key_ready (key_ready),
        .busy      (busy_w[g]),
        .done      (done_w[g]),
        .round     (round_w[g]),
        .rk_req    (rk_req_w[g]),
        .rk_idx    (idx_w[g]),
        .state_ld  (ld_w[g]),
        .in_sel    (sel_w[g])
      );
    end
  endgenerate

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int m_act   [3];
  int m_pos   [3];
  int m_round [3];
  int ecyc;
  int d_first [3];
  int d0_cnt;
  int d0_loads;

  typedef struct {
    logic [63:0] st_m;
    logic [63:0] krl_m;
    logic [63:0] ab_m;
    logic [63:0] rst_m;
    int          d0_first;
    int          d0_cnt;
    int          d0_loads;
    int          d1_first;
    int          d2_first;
  } row_t;

  row_t rows [5];

  function automatic int nr_of(input int id);
    return (id == 2) ? 1 : 10;
  endfunction

  function automatic int ml_of(input int id);
    return (id == 1) ? 3 : 1;
  endfunction

  function automatic logic [13:0] obs(input int id);
    return {busy_w[id], done_w[id], round_w[id], rk_req_w[id], idx_w[id], ld_w[id], sel_w[id]};
  endfunction

  // A run is a fixed timeline of slots: key request, MIX_LAT waits, key request, ... final, done.
  // kind: 0 = wait, 1 = key request, 2 = done
  function automatic void slot_at(input int id, input int pos, output int kind,
                                  output int idx, output logic [1:0] sel);
    int nr  = nr_of(id);
    int ml  = ml_of(id);
    int fin = 1 + (nr - 1) * (ml + 1);
    kind = 2; idx = 0; sel = 2'b00;
    if (pos == 0) begin
      kind = 1; idx = 0; sel = 2'b01;
    end else if (pos < fin) begin
      if ((pos - 1) % (ml + 1) < ml) kind = 0;
      else begin
        kind = 1; idx = (pos - 1) / (ml + 1) + 1; sel = 2'b10;
      end
    end else if (pos == fin) begin
      kind = 1; idx = nr; sel = 2'b11;
    end
  endfunction

  function automatic logic [13:0] model_exp(input int id, input logic kr, input logic ab);
    int kind, idx;
    logic [1:0] sel;
    logic ld;
    logic [3:0] r = 4'(m_round[id]);
    if (m_act[id] == 0) return {2'b00, r, 8'h00};
    slot_at(id, m_pos[id], kind, idx, sel);
    if (kind == 0) return {2'b10, r, 8'h00};
    if (kind == 2) return {2'b01, r, 8'h00};
    ld = kr & ~ab;
    return {2'b10, r, 1'b1, 4'(idx), ld, ld ? sel : 2'b00};
  endfunction

  function automatic void model_upd(input int id, input logic st, input logic kr,
                                    input logic ab, input logic r);
    int kind, idx;
    logic [1:0] sel;
    if (r) begin
      m_act[id] = 0; m_round[id] = 0;
    end else if (m_act[id] == 0) begin
      if (st) begin
        m_act[id] = 1; m_pos[id] = 0; m_round[id] = 0;
      end
    end else begin
      slot_at(id, m_pos[id], kind, idx, sel);
      if (kind == 2) m_act[id] = 0;
      else if (ab) begin
        m_act[id] = 0; m_round[id] = 0;
      end else if (kind == 0) m_pos[id]++;
      else if (kr) begin
        if (sel != 2'b11) m_round[id]++;
        m_pos[id]++;
      end
    end
  endfunction

  task automatic check_vec(input string name, input int id, input logic [13:0] got,
                           input logic [13:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cycle %0d: got %h expected %h (busy,done,round,rk_req,rk_idx,ld,sel)",
               name, id, ecyc, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic cyc(input logic st, input logic kr, input logic ab, input logic r);
    logic [13:0] e [3];
    @(negedge clk);
    start = st; key_ready = kr; abort = ab; rst = r;
    #1;
    for (int i = 0; i < 3; i++) e[i] = model_exp(i, kr, ab);
    for (int i = 0; i < 3; i++) begin
      check_vec("cycle", i, obs(i), e[i]);
      if (done_w[i] && d_first[i] < 0) d_first[i] = ecyc;
      model_upd(i, st, kr, ab, r);
    end
    if (done_w[0]) d0_cnt++;
    if (ld_w[0]) d0_loads++;
    @(posedge clk);
    ecyc++;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      m_act[i] = 0; m_pos[i] = 0; m_round[i] = 0;
    end
    rows[0] = '{64'h1, 64'h0, 64'h0, 64'h0, 21, 1, 11, 39, 3};
    rows[1] = '{64'h1, 64'h0E00, 64'h0, 64'h0, 24, 1, 11, 42, 3};
    rows[2] = '{64'h1 | (64'h1 << 5) | (64'h7 << 20), 64'h0, 64'h0, 64'h0, 21, 2, 22, 39, 3};
    rows[3] = '{64'h1 | (64'h1 << 15), 64'h0, 64'h1 << 12, 64'h0, 36, 1, 17, 54, 3};
    rows[4] = '{64'h1 | (64'h1 << 10), 64'h1 << 7, 64'h0, 64'h1 << 7, 31, 1, 14, 49, 3};

    ecyc = 0;
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) check_vec("reset_state", i, obs(i), 14'h0);

    for (int t = 0; t < 5; t++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b1);
      ecyc = 0; d0_cnt = 0; d0_loads = 0;
      for (int i = 0; i < 3; i++) d_first[i] = -1;
      for (int e = 0; e < 64; e++)
        cyc(rows[t].st_m[e], ~rows[t].krl_m[e], rows[t].ab_m[e], rows[t].rst_m[e]);
      check_int($sformatf("row%0d_done_cycle", t), d_first[0], rows[t].d0_first);
      check_int($sformatf("row%0d_done_count", t), d0_cnt, rows[t].d0_cnt);
      check_int($sformatf("row%0d_load_count", t), d0_loads, rows[t].d0_loads);
      check_int($sformatf("row%0d_mixlat3_done", t), d_first[1], rows[t].d1_first);
      check_int($sformatf("row%0d_nr1_done", t), d_first[2], rows[t].d2_first);
    end

    for (int n = 0; n < 4000; n++)
      cyc($urandom % 6 == 0, $urandom % 4 != 0, $urandom % 64 == 0, $urandom % 300 == 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
